// File: rtl/cordic_iter_ctrl_if.sv
// Command, LUT and step-output signals of the CORDIC iteration sequencer.
// The sequencer takes the slave modport; the command/LUT side takes master.
interface cordic_iter_ctrl_if #(
    parameter int p_WIDTH            = 32,
    parameter int p_ANGLE_ADDR_WIDTH = 5
);
    logic                          start;
    logic                          system;
    logic [p_ANGLE_ADDR_WIDTH:0]   iterations;
    logic [p_ANGLE_ADDR_WIDTH-1:0] lutOffset;
    logic                          lutSystem;
    logic [p_WIDTH-1:0]            lutAngle;
    logic [p_WIDTH-1:0]            stepAngle;
    logic [p_ANGLE_ADDR_WIDTH-1:0] stepShift;
    logic                          stepValid;
    logic                          stepLast;
    logic                          busy;
    logic                          done;

    modport master (
        output start, system, iterations, lutAngle,
        input  lutOffset, lutSystem, stepAngle, stepShift,
        input  stepValid, stepLast, busy, done
    );

    modport slave (
        input  start, system, iterations, lutAngle,
        output lutOffset, lutSystem, stepAngle, stepShift,
        output stepValid, stepLast, busy, done
    );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Walks the CORDIC angle LUT once per clock after a start, one step per iteration; done at N+1.
// Start is only taken in IDLE and never queued. `CORDIC_HYP_REPEAT_EN enables hyperbolic repeats of offsets 4 and 13.
module cordic_iter_ctrl #(
    parameter int p_WIDTH            = 32,
    parameter int p_ANGLE_ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    cordic_iter_ctrl_if.slave    bus
);
    localparam int AW = p_ANGLE_ADDR_WIDTH;
    localparam logic [AW:0]   MAX_COUNT  = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] MAX_OFFSET = {AW{1'b1}};
    localparam logic [AW:0]   ONE_CNT    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_OFF    = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] offset;
    logic          sysReg;
    logic [AW:0]   iterCount;
    logic [AW:0]   stepCount;
    logic          stepValidReg;
    logic          stepLastReg;
    logic          busyReg;
    logic          doneReg;

    logic [AW:0]   clampedIter;
    logic [AW-1:0] firstOffset;
    logic [AW-1:0] incOffset;
    logic [AW:0]   lastIndex;
    logic [AW:0]   stepCountNext;
    logic          isLastStep;
    logic          holdOffset;

    assign clampedIter   = (bus.iterations > MAX_COUNT) ? MAX_COUNT : bus.iterations;
    assign firstOffset   = bus.system ? '0 : ONE_OFF;
    // Saturate at the top LUT entry rather than wrapping back to offset 0.
    assign incOffset     = (offset == MAX_OFFSET) ? offset : offset + ONE_OFF;
    assign lastIndex     = iterCount - ONE_CNT;
    assign stepCountNext = stepCount + ONE_CNT;
    assign isLastStep    = (stepCount == lastIndex);

`ifdef CORDIC_HYP_REPEAT_EN
    localparam logic [AW-1:0] REP_A = AW'(4);
    localparam logic [AW-1:0] REP_B = AW'(13);

    // Set while the current offset is the second issue of a repeated entry.
    logic repeated;

    assign holdOffset = !sysReg && !repeated && ((offset == REP_A) || (offset == REP_B));
`else
    assign holdOffset = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            offset       <= '0;
            sysReg       <= 1'b1;
            iterCount    <= '0;
            stepCount    <= '0;
            stepValidReg <= 1'b0;
            stepLastReg  <= 1'b0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
`ifdef CORDIC_HYP_REPEAT_EN
            repeated     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sysReg    <= bus.system;
                        iterCount <= clampedIter;
                        offset    <= firstOffset;
                        stepCount <= '0;
                        busyReg   <= 1'b1;
`ifdef CORDIC_HYP_REPEAT_EN
                        repeated  <= 1'b0;
`endif
                        if (clampedIter == '0) begin
                            state   <= S_DONE;
                            doneReg <= 1'b1;
                        end else begin
                            state        <= S_RUN;
                            stepValidReg <= 1'b1;
                            stepLastReg  <= (clampedIter == ONE_CNT);
                        end
                    end
                end

                S_RUN: begin
                    if (isLastStep) begin
                        state        <= S_DONE;
                        stepValidReg <= 1'b0;
                        stepLastReg  <= 1'b0;
                        doneReg      <= 1'b1;
                    end else begin
                        stepCount    <= stepCountNext;
                        stepValidReg <= 1'b1;
                        stepLastReg  <= (stepCountNext == lastIndex);
                        if (!holdOffset) begin
                            offset <= incOffset;
                        end
`ifdef CORDIC_HYP_REPEAT_EN
                        repeated <= holdOffset;
`endif
                    end
                end

                S_DONE: begin
                    doneReg <= 1'b0;
                    busyReg <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.lutOffset = offset;
    assign bus.lutSystem = sysReg;
    assign bus.stepAngle = bus.lutAngle;
    assign bus.stepShift = offset;
    assign bus.stepValid = stepValidReg;
    assign bus.stepLast  = stepLastReg;
    assign bus.busy      = busyReg;
    assign bus.done      = doneReg;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: table of runs plus hand sequences for N=0, ignored start and reset abort.
module tb_cordic_iter_ctrl;
    logic clk;
    logic reset;

    cordic_iter_ctrl_if #(.p_WIDTH(32), .p_ANGLE_ADDR_WIDTH(5)) bus ();

    cordic_iter_ctrl #(.p_WIDTH(32), .p_ANGLE_ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Angle LUT model; unlisted entries get distinct tags so a wrong offset shows up in stepAngle.
    function automatic logic [31:0] lutModel(input logic sys, input logic [4:0] off);
        logic [31:0] r;
        if (sys) begin
            case (off)
                5'd0:    r = 32'h20000000;
                5'd1:    r = 32'h12E4051D;
                5'd2:    r = 32'h09FB385B;
                5'd3:    r = 32'h051111D4;
                default: r = 32'hC0DE0000 | {27'd0, off};
            endcase
        end else begin
            r = (off == 5'd4) ? 32'h04005562 : (32'h4A700000 | {27'd0, off});
        end
        return r;
    endfunction

    assign bus.lutAngle = lutModel(bus.lutSystem, bus.lutOffset);

    typedef struct packed {
        logic            sys;
        logic [5:0]      iters;
        logic [5:0]      expSteps;
        logic [7:0][4:0] expOffs;
        logic [4:0]      expLast;
    } vec_t;

    function automatic vec_t mk(input logic sys, input logic [5:0] iters, input logic [5:0] steps,
                                input logic [4:0] o0, input logic [4:0] o1, input logic [4:0] o2,
                                input logic [4:0] o3, input logic [4:0] o4, input logic [4:0] o5,
                                input logic [4:0] o6, input logic [4:0] o7, input logic [4:0] last);
        vec_t v;
        v = '0;
        v.sys = sys;
        v.iters = iters;
        v.expSteps = steps;
        v.expOffs[0] = o0; v.expOffs[1] = o1; v.expOffs[2] = o2; v.expOffs[3] = o3;
        v.expOffs[4] = o4; v.expOffs[5] = o5; v.expOffs[6] = o6; v.expOffs[7] = o7;
        v.expLast = last;
        return v;
    endfunction

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s (case %0d @%0t): got %h, want %h", nm, id, $time, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v, input int id);
        int k;
        int doneAt;
        logic [4:0] e;
        k = 0;
        doneAt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.system = v.sys;
        bus.iterations = v.iters;
        @(posedge clk); #1;
        // Changing the command inputs mid-run must not disturb the latched values.
        bus.start = 1'b0;
        bus.system = ~v.sys;
        bus.iterations = 6'd3;
        for (int c = 1; c <= 40; c++) begin
            chk("busy", id, {31'd0, bus.busy}, 32'd1);
            if (bus.stepValid) begin
                chk("lutSystem", id, {31'd0, bus.lutSystem}, {31'd0, v.sys});
                chk("stepLast", id, {31'd0, bus.stepLast}, {31'd0, (k == int'(v.expSteps) - 1)});
                if (k < 8 || k == int'(v.expSteps) - 1) begin
                    e = (k == int'(v.expSteps) - 1) ? v.expLast : v.expOffs[k];
                    chk("lutOffset", id, {27'd0, bus.lutOffset}, {27'd0, e});
                    chk("stepShift", id, {27'd0, bus.stepShift}, {27'd0, e});
                    chk("stepAngle", id, bus.stepAngle, lutModel(v.sys, e));
                end
                k++;
            end else begin
                chk("stepLastIdle", id, {31'd0, bus.stepLast}, 32'd0);
            end
            if (bus.done) begin
                doneAt = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("stepCount", id, k, {26'd0, v.expSteps});
        chk("doneCycle", id, doneAt, {26'd0, v.expSteps} + 32'd1);
        @(posedge clk); #1;
        chk("busyAfter", id, {31'd0, bus.busy}, 32'd0);
        chk("doneAfter", id, {31'd0, bus.done}, 32'd0);
        chk("lutSystemHeld", id, {31'd0, bus.lutSystem}, {31'd0, v.sys});
    endtask

    vec_t vecs[9];
    int sawDone;

    initial begin
        vecs[0] = mk(1'b1, 6'd4,  6'd4,  0, 1, 2, 3, 0, 0, 0, 0, 3);
`ifdef CORDIC_HYP_REPEAT_EN
        vecs[1] = mk(1'b0, 6'd6,  6'd6,  1, 2, 3, 4, 4, 5, 0, 0, 5);
        vecs[2] = mk(1'b0, 6'd40, 6'd32, 1, 2, 3, 4, 4, 5, 6, 7, 30);
        vecs[5] = mk(1'b0, 6'd16, 6'd16, 1, 2, 3, 4, 4, 5, 6, 7, 14);
`else
        vecs[1] = mk(1'b0, 6'd6,  6'd6,  1, 2, 3, 4, 5, 6, 0, 0, 6);
        vecs[2] = mk(1'b0, 6'd40, 6'd32, 1, 2, 3, 4, 5, 6, 7, 8, 31);
        vecs[5] = mk(1'b0, 6'd16, 6'd16, 1, 2, 3, 4, 5, 6, 7, 8, 16);
`endif
        vecs[3] = mk(1'b1, 6'd40, 6'd32, 0, 1, 2, 3, 4, 5, 6, 7, 31);
        vecs[4] = mk(1'b0, 6'd1,  6'd1,  1, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[6] = mk(1'b1, 6'd0,  6'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[7] = mk(1'b1, 6'd33, 6'd32, 0, 1, 2, 3, 4, 5, 6, 7, 31);
        vecs[8] = mk(1'b1, 6'd32, 6'd32, 0, 1, 2, 3, 4, 5, 6, 7, 31);

        reset = 1'b1;
        bus.start = 1'b0;
        bus.system = 1'b0;
        bus.iterations = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstOffset", 0, {27'd0, bus.lutOffset}, 32'd0);
        chk("rstSystem", 0, {31'd0, bus.lutSystem}, 32'd1);
        chk("rstValid",  0, {31'd0, bus.stepValid}, 32'd0);
        chk("rstLast",   0, {31'd0, bus.stepLast}, 32'd0);
        chk("rstBusy",   0, {31'd0, bus.busy}, 32'd0);
        chk("rstDone",   0, {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            runVec(vecs[i], i + 1);
        end

        // N=0 with a start pulse during the done cycle: the pulse is dropped.
        @(negedge clk);
        bus.start = 1'b1;
        bus.system = 1'b0;
        bus.iterations = 6'd0;
        @(posedge clk); #1;
        chk("n0Done",  20, {31'd0, bus.done}, 32'd1);
        chk("n0Valid", 20, {31'd0, bus.stepValid}, 32'd0);
        chk("n0Busy",  20, {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b1;
        bus.iterations = 6'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ignBusy",  21, {31'd0, bus.busy}, 32'd0);
        chk("ignDone",  21, {31'd0, bus.done}, 32'd0);
        chk("ignValid", 21, {31'd0, bus.stepValid}, 32'd0);
        @(posedge clk); #1;
        chk("ignBusy2",  22, {31'd0, bus.busy}, 32'd0);
        chk("ignValid2", 22, {31'd0, bus.stepValid}, 32'd0);
        chk("ignSystem", 22, {31'd0, bus.lutSystem}, 32'd0);

        // Circular N=8 aborted by reset asserted in cycle 3.
        @(negedge clk);
        bus.start = 1'b1;
        bus.system = 1'b1;
        bus.iterations = 6'd8;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("abC1Offset", 30, {27'd0, bus.lutOffset}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abC3Offset", 30, {27'd0, bus.lutOffset}, 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abOffset", 31, {27'd0, bus.lutOffset}, 32'd0);
        chk("abSystem", 31, {31'd0, bus.lutSystem}, 32'd1);
        chk("abValid",  31, {31'd0, bus.stepValid}, 32'd0);
        chk("abLast",   31, {31'd0, bus.stepLast}, 32'd0);
        chk("abBusy",   31, {31'd0, bus.busy}, 32'd0);
        chk("abDone",   31, {31'd0, bus.done}, 32'd0);
        sawDone = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done || bus.stepValid) sawDone = 1;
            @(posedge clk); #1;
        end
        chk("abNoDone", 32, sawDone, 32'd0);

        runVec(mk(1'b1, 6'd2, 6'd2, 0, 1, 0, 0, 0, 0, 0, 0, 1), 33);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
